// File: rtl/clk_test_window_ctrl.sv
// clk_test_window_ctrl: counts clk_test cycles inside a gated window and hands the frozen
// result to the clk_ref side through a toggle request/acknowledge handshake.
module clk_test_window_ctrl #(
    parameter int COUNTER_WIDTH = 32,
    parameter int MISS_WIDTH    = 8
) (
    input  logic                     clk_test,
    input  logic                     async_reset_clk_test,
    input  logic                     enable,
    input  logic                     gate_sync,
    input  logic                     ack_toggle_sync,
    output logic [COUNTER_WIDTH-1:0] count_hold,
    output logic                     overflow_hold,
    output logic                     req_toggle,
    output logic                     req_pending,
    output logic                     busy,
    output logic [MISS_WIDTH-1:0]    missed_count,
    output logic [1:0]               state_out
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, COUNT = 2'd2, HOLD = 2'd3} state_t;
    state_t                   state_q;
    logic                     gate_q;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic                     ovf_q;
    logic [COUNTER_WIDTH-1:0] hold_q;
    logic                     hovf_q;
    logic                     req_q;
    logic [MISS_WIDTH-1:0]    miss_q;
    logic                     rise;
    logic                     fall;
    assign rise = gate_sync & ~gate_q;
    assign fall = ~gate_sync & gate_q;
    always_ff @(posedge clk_test or posedge async_reset_clk_test) begin
        if (async_reset_clk_test) begin
            state_q <= IDLE;
            gate_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= '0;
            hovf_q  <= 1'b0;
            req_q   <= 1'b0;
            miss_q  <= '0;
        end else begin
            gate_q <= gate_sync;
            case (state_q)
                IDLE: if (enable) state_q <= ARMED;
                ARMED:
                    if (!enable) state_q <= IDLE;
                    else if (rise) begin
                        cnt_q   <= COUNTER_WIDTH'(1);
                        ovf_q   <= 1'b0;
                        state_q <= COUNT;
                    end
                COUNT:
                    if (!enable) state_q <= IDLE;
                    else if (gate_sync) begin
                        if (&cnt_q) ovf_q <= 1'b1;
                        else cnt_q <= cnt_q + COUNTER_WIDTH'(1);
                    end else if (fall) begin
                        hold_q  <= cnt_q;
                        hovf_q  <= ovf_q;
                        req_q   <= ~req_q;
                        state_q <= HOLD;
                    end
                HOLD: begin
                    // a handshake in flight always completes, even when disabled
                    if (rise && !(&miss_q)) miss_q <= miss_q + MISS_WIDTH'(1);
                    if (ack_toggle_sync == req_q) state_q <= enable ? ARMED : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign count_hold    = hold_q;
    assign overflow_hold = hovf_q;
    assign req_toggle    = req_q;
    assign req_pending   = req_q ^ ack_toggle_sync;
    assign busy          = state_q[1];
    assign missed_count  = miss_q;
    assign state_out     = state_q;
endmodule

// File: tb/tb_clk_test_window_ctrl.sv
// tb_clk_test_window_ctrl: drives a full-width and a narrow (4-bit count, 2-bit miss)
// instance with shared stimulus and checks both against window-level expectations.
module tb_clk_test_window_ctrl;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, gate = 1'b0, ack = 1'b0;
    logic [31:0] ha;
    logic [3:0]  hb;
    logic [7:0]  ma;
    logic [1:0]  mb, sa, sb;
    logic        oa, ob, ra, rb, pa, pb, ba, bb;
    int checks = 0, failures = 0;
    int exp_ha = 0, exp_hb = 0, exp_ob = 0, exp_req = 0, exp_miss = 0;

    always #5 clk = ~clk;

    clk_test_window_ctrl dut_a (
        .clk_test(clk), .async_reset_clk_test(rst), .enable(en), .gate_sync(gate),
        .ack_toggle_sync(ack), .count_hold(ha), .overflow_hold(oa), .req_toggle(ra),
        .req_pending(pa), .busy(ba), .missed_count(ma), .state_out(sa));

    clk_test_window_ctrl #(.COUNTER_WIDTH(4), .MISS_WIDTH(2)) dut_b (
        .clk_test(clk), .async_reset_clk_test(rst), .enable(en), .gate_sync(gate),
        .ack_toggle_sync(ack), .count_hold(hb), .overflow_hold(ob), .req_toggle(rb),
        .req_pending(pb), .busy(bb), .missed_count(mb), .state_out(sb));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input int st);
        int pend;
        pend = exp_req ^ int'(ack);
        chk({tag, ".a.state"}, 64'(sa), 64'(st));
        chk({tag, ".b.state"}, 64'(sb), 64'(st));
        chk({tag, ".a.busy"}, 64'(ba), 64'(st == 2 || st == 3));
        chk({tag, ".b.busy"}, 64'(bb), 64'(st == 2 || st == 3));
        chk({tag, ".a.hold"}, 64'(ha), 64'(exp_ha));
        chk({tag, ".b.hold"}, 64'(hb), 64'(exp_hb));
        chk({tag, ".a.ovf"}, 64'(oa), 64'(0));
        chk({tag, ".b.ovf"}, 64'(ob), 64'(exp_ob));
        chk({tag, ".a.req"}, 64'(ra), 64'(exp_req));
        chk({tag, ".b.req"}, 64'(rb), 64'(exp_req));
        chk({tag, ".a.pend"}, 64'(pa), 64'(pend));
        chk({tag, ".b.pend"}, 64'(pb), 64'(pend));
        chk({tag, ".a.miss"}, 64'(ma), 64'(exp_miss > 255 ? 255 : exp_miss));
        chk({tag, ".b.miss"}, 64'(mb), 64'(exp_miss > 3 ? 3 : exp_miss));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic window(input int n);
        gate = 1'b1;
        tick(n);
        chk_all("win_open", 2);
        gate = 1'b0;
        tick(1);
        exp_req ^= 1;
        exp_ha = n;
        exp_hb = n > 15 ? 15 : n;
        exp_ob = n > 15 ? 1 : 0;
        chk_all("win_close", 3);
    endtask

    task automatic ack_it();
        ack = exp_req[0];
        tick(1);
        chk_all("ack", en ? 1 : 0);
    endtask

    task automatic lose(input int m);
        repeat (m) begin
            gate = 1'b1;
            tick(int'($urandom_range(1, 4)));
            gate = 1'b0;
            tick(1);
            exp_miss++;
        end
        chk_all("missed", 3);
    endtask

    task automatic clear_model();
        exp_ha = 0; exp_hb = 0; exp_ob = 0; exp_req = 0; exp_miss = 0;
    endtask

    initial begin
        tick(2);
        chk_all("reset", 0);
        rst = 1'b0;
        tick(1);
        chk_all("idle", 0);
        en = 1'b1;
        tick(1);
        chk_all("armed", 1);
        window(100);
        lose(2);
        ack_it();
        window(5);
        ack_it();
        window(15);
        ack_it();
        window(16);
        ack_it();
        window(1);
        lose(3);
        ack_it();
        for (int k = 0; k < 6; k++) begin
            window(int'($urandom_range(1, 40)));
            if ($urandom_range(0, 1) == 1) lose(int'($urandom_range(1, 3)));
            ack_it();
        end
        en = 1'b0;
        tick(1);
        chk_all("disable", 0);
        gate = 1'b1;
        tick(1);
        en = 1'b1;
        tick(7);
        chk_all("gate_pre_high", 1);
        gate = 1'b0;
        tick(1);
        chk_all("gate_low", 1);
        window(30);
        ack_it();
        gate = 1'b1;
        tick(5);
        chk_all("abort_pre", 2);
        en = 1'b0;
        tick(1);
        chk_all("abort", 0);
        gate = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
        chk_all("rearm", 1);
        window(int'($urandom_range(2, 20)));
        en = 1'b0;
        tick(3);
        chk_all("hold_disabled", 3);
        ack_it();
        en = 1'b1;
        tick(1);
        chk_all("rearm2", 1);
        gate = 1'b1;
        tick(3);
        #2 rst = 1'b1;
        #1 clear_model();
        ack = 1'b0;
        #1 chk_all("reset_count", 0);
        gate = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk_all("post_reset", 1);
        window(8);
        lose(1);
        #2 rst = 1'b1;
        #1 clear_model();
        ack = 1'b0;
        #1 chk_all("reset_hold", 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk_all("final", 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_test_window_ctrl.md
Name: clk_test_window_ctrl

Overview:
- Sequences one clk_rate measurement channel entirely inside the clk_test domain.
- Counts clk_test cycles while a reference-derived gate is high, then freezes the result.
- Passes the frozen result to the clk_ref domain with a toggle request/acknowledge handshake.
- Detects lost windows, counter saturation and enable aborts. Lets the clk_ref side read a stable value without gray-coding a free-running counter.

Parameters:
- COUNTER_WIDTH, 32, width of window counter and held result.
- MISS_WIDTH, 8, width of saturating missed-window counter.

Ports:
- clk_test  input  1  test clock; all logic is in this domain.
- async_reset_clk_test  input  1  asynchronous, active-high reset.
- enable  input  1  already synchronized to clk_test; 0 forces IDLE.
- gate_sync  input  1  measurement gate from the clk_ref domain, already 2-FF synchronized to clk_test; high = window open.
- ack_toggle_sync  input  1  acknowledge toggle from clk_ref, already synchronized to clk_test.
- count_hold  output  COUNTER_WIDTH  frozen window count; stable while req_pending=1.
- overflow_hold  output  1  frozen saturation flag for count_hold.
- req_toggle  output  1  flips once per published result.
- req_pending  output  1  req_toggle != ack_toggle_sync.
- busy  output  1  state is COUNT or HOLD.
- missed_count  output  MISS_WIDTH  windows lost while HOLD; saturating.
- state_out  output  2  IDLE=0, ARMED=1, COUNT=2, HOLD=3.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; gate_d=0; counter=0; count_hold=0; overflow_hold=0; req_toggle=0; missed_count=0.
- Edge detect is registered:
  - rise = gate_sync & ~gate_d.
  - fall = ~gate_sync & gate_d.
  - gate_d <= gate_sync every cycle.
- IDLE: when enable=1, go to ARMED next cycle. rise is ignored in IDLE, even on the same cycle.
- ARMED: on rise, counter <= 1, ovf <= 0, go to COUNT. A gate already high on entry is not counted; the block waits for the next rise.
- COUNT, gate_sync=1:
  - counter <= counter+1, saturating at all-ones.
  - ovf <= 1 when an increment is attempted at all-ones.
  - Result = number of clk_test cycles with gate_sync=1.
- COUNT, fall:
  - count_hold <= counter; overflow_hold <= ovf; req_toggle flips; go to HOLD, all in the same edge.
  - Latency from first gate_sync=0 cycle to new count_hold/req_toggle: 1 clk_test edge.
- HOLD:
  - count_hold, overflow_hold and req_toggle are frozen.
  - Go to ARMED on the first cycle ack_toggle_sync == req_toggle.
  - A rise seen in HOLD increments missed_count, saturating at 2^MISS_WIDTH-1, and is not measured.
  - A rise on the same cycle as the ack match is counted as missed, and the block enters ARMED.
- enable=0 in ARMED or COUNT: go to IDLE next cycle. The window is discarded; count_hold and req_toggle are unchanged.
- enable=0 in HOLD: remain in HOLD until acked, then go to IDLE instead of ARMED. A handshake is never abandoned.
- Registered outputs:
  - req_pending is combinational from req_toggle and ack_toggle_sync.
  - busy and state_out are decoded from the state register.
- Reset mid-handshake: req_toggle returns to 0. The clk_ref side must reset together via the shared reset tree; no recovery protocol.

Test Plan:
- Reset, enable=1, gate high 100 cycles then low -> count_hold=100, overflow_hold=0, req_toggle 0->1 one edge after first low cycle, state HOLD, req_pending=1.
- Hold ack_toggle_sync=0, pulse gate high 10 cycles twice -> missed_count=2, count_hold stays 100; set ack_toggle_sync=1 -> ARMED next edge, req_pending=0.
- COUNTER_WIDTH=4, gate high 20 cycles -> count_hold=15, overflow_hold=1; next window 5 cycles -> count_hold=5, overflow_hold=0.
- enable=1 asserted while gate already high for 7 more cycles -> no count; next 30-cycle window -> count_hold=30.
- enable=0 at cycle 5 of a window -> IDLE, req_toggle unchanged; enable=0 during HOLD -> stays HOLD until ack, then IDLE.
- Async reset asserted mid-COUNT and mid-HOLD -> all outputs 0 immediately, state IDLE; MISS_WIDTH=2 with 5 missed windows -> missed_count=3.
